// File: rtl/spi_control_fsm_pkg.sv
// Shared definitions for the SPI slave control FSM: state encoding,
// R/W bit position and bit-counter width.
package spi_control_fsm_pkg;

   typedef enum logic [2:0] {
      ST_IDLE         = 3'd0,
      ST_GET_ADDR     = 3'd1,
      ST_GOT_ADDR     = 3'd2,
      ST_READ_LOAD    = 3'd3,
      ST_READ_SHIFT   = 3'd4,
      ST_WRITE_RECV   = 3'd5,
      ST_WRITE_COMMIT = 3'd6,
      ST_DONE         = 3'd7
   } state_e;

   localparam int unsigned RW_BIT = 0;
   localparam int unsigned CNT_W  = 4;

   // States in which SCLK edges advance the bit counter.
   function automatic logic is_counting(input state_e s);
      return (s == ST_GET_ADDR) || (s == ST_READ_SHIFT) || (s == ST_WRITE_RECV);
   endfunction

endpackage

// File: rtl/spi_control_fsm_edge_counter.sv
// Bit counter for SCLK edges; clear has priority over enable.
module edge_counter #(
   parameter int unsigned W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear,
   input  logic         enable,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count_q <= '0;
      end else if (enable) begin
         count_q <= count_q + 1'b1;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/spi_control_fsm.sv
// SPI slave control FSM: receives an address/RW byte, then either
// streams a read byte out or collects and commits a write byte.
module spi_control_fsm
   import spi_control_fsm_pkg::*;
#(
   parameter int unsigned width = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             csConditioned,
   input  logic             peripheralClkEdge,
   input  logic [width-1:0] shiftRegDataIn,
   output logic             parallelLoad,
   output logic [width-2:0] address,
   output logic             dmWriteEnable,
   output logic             misoBufferEnable,
   output logic             busy
);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   bit_count;
   logic               cnt_full;
   logic               rw_q;
   logic [width-2:0]   address_q;
   logic               pl_q, dm_q, miso_q, busy_q;

   edge_counter #(.W(CNT_W)) u_edge_counter (
      .clk    (clk),
      .reset  (reset),
      .clear  (state_d != state_q),
      .enable (peripheralClkEdge && is_counting(state_q)),
      .count  (bit_count)
   );

   assign cnt_full = (bit_count == CNT_W'(width));

   // CS release wins over every other transition, including a final edge.
   always_comb begin
      state_d = state_q;
      if (state_q != ST_IDLE && csConditioned) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE:         if (!csConditioned) state_d = ST_GET_ADDR;
            ST_GET_ADDR:     if (cnt_full) state_d = ST_GOT_ADDR;
            ST_GOT_ADDR:     state_d = rw_q ? ST_READ_LOAD : ST_WRITE_RECV;
            ST_READ_LOAD:    state_d = ST_READ_SHIFT;
            ST_READ_SHIFT:   if (cnt_full) state_d = ST_DONE;
            ST_WRITE_RECV:   if (cnt_full) state_d = ST_WRITE_COMMIT;
            ST_WRITE_COMMIT: state_d = ST_DONE;
            ST_DONE:         state_d = ST_DONE;
            default:         state_d = ST_IDLE;
         endcase
      end
   end

   // Address/RW are captured on the edge entering GOT_ADDR so they are
   // stable throughout GOT_ADDR and steer its exit.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         address_q <= '0;
         rw_q      <= 1'b0;
         pl_q      <= 1'b0;
         dm_q      <= 1'b0;
         miso_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         pl_q    <= (state_d == ST_READ_LOAD);
         dm_q    <= (state_d == ST_WRITE_COMMIT);
         miso_q  <= (state_d == ST_READ_SHIFT);
         busy_q  <= (state_d != ST_IDLE);
         if (state_q == ST_GET_ADDR && state_d == ST_GOT_ADDR) begin
            address_q <= shiftRegDataIn[width-1:1];
            rw_q      <= shiftRegDataIn[RW_BIT];
         end
      end
   end

   assign parallelLoad     = pl_q;
   assign dmWriteEnable    = dm_q;
   assign misoBufferEnable = miso_q;
   assign busy             = busy_q;
   assign address          = address_q;

endmodule

// File: tb/tb_spi_control_fsm.sv
// Self-checking bench for spi_control_fsm: directed scenarios plus random
// transactions, checked every cycle against an event-time reference model.
module tb_spi_control_fsm;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       csConditioned = 1'b1;
   logic       peripheralClkEdge = 1'b0;
   logic [7:0] shiftRegDataIn = '0;
   logic       parallelLoad;
   logic [6:0] address;
   logic       dmWriteEnable;
   logic       misoBufferEnable;
   logic       busy;

   always #5 clk = ~clk;

   spi_control_fsm #(.width(8)) dut (
      .clk               (clk),
      .reset             (reset),
      .csConditioned     (csConditioned),
      .peripheralClkEdge (peripheralClkEdge),
      .shiftRegDataIn    (shiftRegDataIn),
      .parallelLoad      (parallelLoad),
      .address           (address),
      .dmWriteEnable     (dmWriteEnable),
      .misoBufferEnable  (misoBufferEnable),
      .busy              (busy)
   );

   int         checks = 0;
   int         errors = 0;
   int         t = 0;
   int         np = 0;
   int         p8 = -1;
   int         p16 = -1;
   logic       txn_on = 1'b0;
   logic       cur_rd = 1'b0;
   logic [6:0] cur_addr = '0;
   logic [6:0] exp_addr = '0;
   logic [7:0] sr = '0;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, got, exp, t);
      end
   endtask

   // One clock: drive inputs, advance the model, compare every output.
   // Model: a transaction spans CS-low to CS-high; with p8/p16 the cycles of
   // the 8th/16th counted edge, address appears at p8+1, load at p8+2,
   // MISO from p8+3 through p16, write strobe at p16+1.
   task automatic step(input logic rst, input logic cs, input logic pulse, input logic mosi);
      logic was_on, e_pl, e_dm, e_miso;
      reset = rst;
      csConditioned = cs;
      peripheralClkEdge = pulse;
      @(posedge clk);
      #1;
      t++;
      if (pulse) begin
         sr = {sr[6:0], mosi};
         shiftRegDataIn = sr;
      end
      was_on = txn_on;
      if (rst) begin
         txn_on = 1'b0;
         exp_addr = '0;
      end else if (cs) begin
         txn_on = 1'b0;
      end else if (!txn_on) begin
         txn_on = 1'b1;
         np = 0;
         p8 = -1;
         p16 = -1;
      end
      if (was_on && pulse) begin
         np++;
         if (np == 8) p8 = t;
         if (np == 16) p16 = t;
      end
      if (txn_on && p8 >= 0 && t == p8 + 1) exp_addr = cur_addr;
      e_pl   = txn_on && cur_rd && p8 >= 0 && t == p8 + 2;
      e_miso = txn_on && cur_rd && p8 >= 0 && t >= p8 + 3 && (p16 < 0 || t <= p16);
      e_dm   = txn_on && !cur_rd && p16 >= 0 && t == p16 + 1;
      chk("busy", {7'b0, busy}, {7'b0, txn_on});
      chk("parallelLoad", {7'b0, parallelLoad}, {7'b0, e_pl});
      chk("dmWriteEnable", {7'b0, dmWriteEnable}, {7'b0, e_dm});
      chk("misoBufferEnable", {7'b0, misoBufferEnable}, {7'b0, e_miso});
      chk("address", {1'b0, address}, {1'b0, exp_addr});
   endtask

   // mode: 0 complete, 1 CS high after stop_at edges, 2 CS high together with
   // edge stop_at, 3 reset after stop_at edges.
   task automatic run_txn(input logic rd, input logic [6:0] a, input logic [7:0] d,
                          input int unsigned stop_at, input int unsigned mode);
      logic [15:0] bits;
      int unsigned npulse, gap;
      bits = {a, rd, d};
      cur_rd = rd;
      cur_addr = a;
      npulse = (mode == 0) ? 16 : stop_at;
      step(1'b0, 1'b0, 1'b0, 1'b0);
      for (int unsigned i = 0; i < npulse; i++) begin
         gap = (i == 8) ? ((rd ? 3 : 2) + $urandom_range(0, 1)) : $urandom_range(0, 2);
         for (int unsigned g = 0; g < gap; g++) step(1'b0, 1'b0, 1'b0, 1'b0);
         step(1'b0, (mode == 2) && (i == npulse - 1), 1'b1, bits[15 - i]);
      end
      if (mode == 0) begin
         gap = 2 + $urandom_range(0, 1);
         for (int unsigned g = 0; g < gap; g++) step(1'b0, 1'b0, 1'b0, 1'b0);
      end else if (mode == 3) begin
         step(1'b0, 1'b0, 1'b0, 1'b0);
         step(1'b1, 1'b0, 1'b0, 1'b0);
      end
      step(1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0);
   endtask

   initial begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b0, 1'b0);

      run_txn(1'b0, 7'h2A, 8'($urandom), 16, 0);
      run_txn(1'b1, 7'h2A, 8'($urandom), 16, 0);
      run_txn(1'b0, 7'h15, 8'($urandom), 16, 0);
      run_txn(1'b0, 7'h2A, 8'($urandom), 12, 1);
      run_txn(1'b0, 7'h33, 8'($urandom), 16, 2);
      run_txn(1'b1, 7'h4C, 8'($urandom), 11, 3);

      for (int unsigned i = 0; i < 5; i++) begin
         step(1'b0, 1'b1, 1'b1, 1'($urandom));
         step(1'b0, 1'b1, 1'b0, 1'b0);
      end
      run_txn(1'b1, 7'h01, 8'($urandom), 16, 0);

      for (int unsigned k = 0; k < 12; k++) begin
         if ($urandom_range(0, 3) == 0)
            run_txn(1'($urandom), 7'($urandom), 8'($urandom), $urandom_range(1, 15), 1);
         else
            run_txn(1'($urandom), 7'($urandom), 8'($urandom), 16, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
